// File: rtl/csr_access_arbiter.sv
// csr_access_arbiter: shares the host CSR strobe port among NUM_REQ requesters.
// Arbitration is round-robin unless CSR_ARB_FIXED_PRIO_EN is defined (lowest index wins).
module csr_access_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 512,
  parameter int HOLD_CYCLES = 10,
  parameter int GAP_CYCLES  = 10
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      busy,
  output logic                      h2f_csr_read,
  output logic                      h2f_csr_write,
  output logic [ADDR_W-1:0]         h2f_csr_addr,
  output logic [DATA_W-1:0]         h2f_csr_wrData,
  input  logic [DATA_W-1:0]         f2h_csr_rdData
);

  // state     | meaning
  // S_IDLE    | no access; grant issued here, leave the cycle after req_ready
  // S_ACCESS  | strobe asserted, HOLD_CYCLES cycles
  // S_RECOVER | strobes low, GAP_CYCLES cycles
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} state_t;

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(NUM_REQ);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    win, win_q;
  logic                found;
  logic                grant_fire, access_done;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [NUM_REQ-1:0]  ready_d, rsp_valid_d;
  logic [DATA_W-1:0]   rdata_d, wrdata_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                read_d, write_d, busy_d;

`ifdef CSR_ARB_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        found = 1'b1;
        win   = IDX_W'(k);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)
      rr_ptr <= '0;
    else if (grant_fire)
      rr_ptr <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  end
`endif

  // State register, timer and captured request
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      win_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && state_nxt == S_ACCESS)
        cnt <= CNT_W'(HOLD_CYCLES - 1);
      else if (access_done)
        cnt <= CNT_W'(GAP_CYCLES - 1);
      else if (cnt != '0)
        cnt <= cnt - 1'b1;
      if (grant_fire) begin
        win_q   <= win;
        wr_q    <= req_write[win];
        addr_q  <= req_addr[win*ADDR_W +: ADDR_W];
        wdata_q <= req_wdata[win*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (req_ready != '0) state_nxt = S_ACCESS;
      S_ACCESS:  if (cnt == '0) state_nxt = S_RECOVER;
      S_RECOVER: if (cnt == '0) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Grants also fire on the last RECOVER cycle so the next access starts without a dead IDLE cycle
  assign access_done = (state == S_ACCESS) && (cnt == '0);
  assign grant_fire  = (state_nxt == S_IDLE) && found;

  always_comb begin
    ready_d     = '0;
    rsp_valid_d = '0;
    rdata_d     = rsp_rdata;
    addr_d      = h2f_csr_addr;
    read_d      = 1'b0;
    write_d     = 1'b0;
    wrdata_d    = '0;
    busy_d      = (state_nxt != S_IDLE);
    if (grant_fire)
      ready_d[win] = 1'b1;
    if (access_done) begin
      rsp_valid_d[win_q] = 1'b1;
      if (!wr_q) rdata_d = f2h_csr_rdData;
    end
    if (state_nxt == S_ACCESS) begin
      addr_d  = addr_q;
      read_d  = !wr_q;
      write_d = wr_q;
      if (wr_q) wrdata_d = wdata_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      req_ready      <= '0;
      rsp_valid      <= '0;
      rsp_rdata      <= '0;
      busy           <= 1'b0;
      h2f_csr_read   <= 1'b0;
      h2f_csr_write  <= 1'b0;
      h2f_csr_addr   <= '0;
      h2f_csr_wrData <= '0;
    end else begin
      req_ready      <= ready_d;
      rsp_valid      <= rsp_valid_d;
      rsp_rdata      <= rdata_d;
      busy           <= busy_d;
      h2f_csr_read   <= read_d;
      h2f_csr_write  <= write_d;
      h2f_csr_addr   <= addr_d;
      h2f_csr_wrData <= wrdata_d;
    end
  end

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Directed bench for csr_access_arbiter: a HOLD=GAP=10 instance backed by a small CSR
// memory model, plus a HOLD=GAP=1 instance for back-to-back reads.
module tb_csr_access_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 512;
`ifdef CSR_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, h2f_csr_wrData, f2h_csr_rdData;
  logic            busy, h2f_csr_read, h2f_csr_write;
  logic [AW-1:0]   h2f_csr_addr;

  logic [N-1:0]    f_valid, f_wr, f_ready, f_rsp;
  logic [N*AW-1:0] f_addr;
  logic [N*DW-1:0] f_wdata;
  logic [DW-1:0]   f_rdata, f_wrdata, f_rd_in;
  logic            f_busy, f_read, f_write;
  logic [AW-1:0]   f_csr_addr;

  csr_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .HOLD_CYCLES(10), .GAP_CYCLES(10)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .busy(busy), .h2f_csr_read(h2f_csr_read), .h2f_csr_write(h2f_csr_write),
    .h2f_csr_addr(h2f_csr_addr), .h2f_csr_wrData(h2f_csr_wrData), .f2h_csr_rdData(f2h_csr_rdData));

  csr_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .HOLD_CYCLES(1), .GAP_CYCLES(1)) u_dut_fast (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req_valid(f_valid), .req_write(f_wr),
    .req_addr(f_addr), .req_wdata(f_wdata), .req_ready(f_ready), .rsp_valid(f_rsp),
    .rsp_rdata(f_rdata), .busy(f_busy), .h2f_csr_read(f_read), .h2f_csr_write(f_write),
    .h2f_csr_addr(f_csr_addr), .h2f_csr_wrData(f_wrdata), .f2h_csr_rdData(f_rd_in));

  logic [DW-1:0] mem [16];
  always @(posedge sys_clk) begin
    if (!sys_rst_n)
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    else if (h2f_csr_write)
      mem[h2f_csr_addr[3:0]] <= h2f_csr_wrData;
  end
  assign f2h_csr_rdData = mem[h2f_csr_addr[3:0]];
  assign f_rd_in = DW'(f_csr_addr) + DW'(1000);

  int n_chk = 0, n_err = 0, cyc = 0, overlap = 0, rsp0_cnt = 0;
  int w, t0, tp, snap;

  always @(negedge sys_clk) begin
    if (h2f_csr_read && h2f_csr_write) overlap++;
    if (f_read && f_write) overlap++;
    if (rsp_valid[0]) rsp0_cnt++;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int i, input logic v, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_write[i]           = wr;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  task automatic wait_grant(input int budget, output int waited);
    waited = 0;
    do begin tick(); waited++; end while (req_ready == '0 && waited < budget);
  endtask

  task automatic wait_rsp(input int budget);
    int k;
    k = 0;
    do begin tick(); k++; end while (rsp_valid == '0 && k < budget);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin tick(); k++; end
  endtask

  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    f_valid = '0; f_wr = '0; f_addr = '0; f_wdata = '0;
    repeat (2) tick();
    chk("rst_ctl", {req_ready, rsp_valid, busy, h2f_csr_read, h2f_csr_write}, '0);
    chk("rst_addr", h2f_csr_addr, '0);
    chk("rst_wdata", h2f_csr_wrData, '0);
    chk("rst_rdata", rsp_rdata, '0);
    sys_rst_n = 1'b1;

    // single write
    set_req(0, 1, 1, 0, 10);
    wait_grant(5, w);
    chk("t1_ready", req_ready, 4'b0001);
    chk("t1_busy_T", busy, 0);
    for (int j = 1; j <= 21; j++) begin
      tick();
      if (j == 1) set_req(0, 0, 0, 0, 0);
      chk("t1_wr_strobe", h2f_csr_write, (j <= 10));
      if (j == 1) begin
        chk("t1_addr", h2f_csr_addr, 0);
        chk("t1_wdata", h2f_csr_wrData, 10);
        chk("t1_busy", busy, 1);
      end
      if (j == 10) chk("t1_wdata_last", h2f_csr_wrData, 10);
      if (j == 11) begin
        chk("t1_rsp", rsp_valid, 4'b0001);
        chk("t1_wdata_gap", h2f_csr_wrData, 0);
      end
      if (j == 20) chk("t1_busy_gap", busy, 1);
      if (j == 21) chk("t1_busy_end", busy, 0);
    end

    // read-back
    set_req(1, 1, 0, 0, 0);
    wait_grant(5, w);
    chk("t2_ready", req_ready, 4'b0010);
    for (int j = 1; j <= 11; j++) begin
      tick();
      if (j == 1) begin
        set_req(1, 0, 0, 0, 0);
        chk("t2_wdata0", h2f_csr_wrData, 0);
        chk("t2_nowr", h2f_csr_write, 0);
      end
      chk("t2_rd_strobe", h2f_csr_read, (j <= 10));
      if (j == 11) begin
        chk("t2_rsp", rsp_valid, 4'b0010);
        chk("t2_rdata", rsp_rdata, 10);
      end
    end

    // contention from reset
    sys_rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1, 1, i, i + 1);
    repeat (2) tick();
    sys_rst_n = 1'b1;
    tp = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(30, w);
      chk("t3_order", req_ready, FIXED ? 4'b0001 : (4'b0001 << (g % N)));
      if (g > 0) chk("t3_spacing", cyc - tp, 21);
      tp = cyc;
    end
    tick();
    req_valid = '0;
    wait_idle(40);
    chk("t3_idle", busy, 0);

    // late arrival during RECOVER
    set_req(0, 1, 1, 4, 77);
    wait_grant(5, w);
    chk("t4_ready0", req_ready, 4'b0001);
    t0 = cyc;
    tick();
    set_req(0, 0, 0, 0, 0);
    repeat (14) tick();
    set_req(2, 1, 0, 2, 0);
    wait_grant(20, w);
    chk("t4_ready2", req_ready, 4'b0100);
    chk("t4_grant_time", cyc - t0, 21);
    tick();
    set_req(2, 0, 0, 0, 0);
    chk("t4_rd_strobe", h2f_csr_read, 1);
    wait_rsp(20);
    chk("t4_rsp", rsp_valid, 4'b0100);
    chk("t4_rdata", rsp_rdata, FIXED ? 0 : 3);
    wait_idle(20);

    // reset during ACCESS
    set_req(0, 1, 1, 1, 55);
    wait_grant(5, w);
    chk("t5_ready0", req_ready, 4'b0001);
    tick();
    set_req(0, 0, 0, 0, 0);
    set_req(3, 1, 0, 4, 0);
    repeat (4) tick();
    chk("t5_in_access", h2f_csr_write, 1);
    snap = rsp0_cnt;
    sys_rst_n = 1'b0;
    tick();
    chk("t5_rst_ctl", {req_ready, rsp_valid, busy, h2f_csr_read, h2f_csr_write}, '0);
    chk("t5_rst_addr", h2f_csr_addr, '0);
    chk("t5_rst_wdata", h2f_csr_wrData, '0);
    chk("t5_rst_rdata", rsp_rdata, '0);
    sys_rst_n = 1'b1;
    wait_grant(5, w);
    chk("t5_ready3", req_ready, 4'b1000);
    tick();
    set_req(3, 0, 0, 0, 0);
    wait_rsp(20);
    chk("t5_rsp3", rsp_valid, 4'b1000);
    chk("t5_no_rsp0", rsp0_cnt - snap, 0);
    wait_idle(20);

    // HOLD=1 GAP=1 back-to-back reads
    f_addr[0 +: AW]  = 5;
    f_addr[AW +: AW] = 6;
    f_valid = 4'b0011;
    w = 0;
    do begin tick(); w++; end while (f_ready == '0 && w < 5);
    chk("t6_ready0", f_ready, 4'b0001);
    for (int j = 1; j <= 5; j++) begin
      tick();
      if (j == 1) f_valid[0] = 1'b0;
      if (j == 4) f_valid[1] = 1'b0;
      chk("t6_rd_strobe", f_read, (j == 1 || j == 4));
      chk("t6_ready", f_ready, (j == 3) ? 4'b0010 : 4'b0000);
      chk("t6_rsp", f_rsp, (j == 2) ? 4'b0001 : (j == 5) ? 4'b0010 : 4'b0000);
      if (j == 2) chk("t6_rdata0", f_rdata, 1005);
      if (j == 5) chk("t6_rdata1", f_rdata, 1006);
    end

    chk("no_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
